axi_lsu_demux: RTL and testbench
================================

AXI_LSU_DEMUX -- requirements
Module: axi_lsu_demux

Interface
REQ-001 Parameter S0_BASE, default 32'h1000_0000, base address of slave 0 (DRAM).
REQ-002 Parameter S0_MASK, default 32'hF000_0000, address bits compared for slave 0.
REQ-003 Parameter S1_BASE, default 32'h2000_0000, base address of slave 1 (MMIO).
REQ-004 Parameter S1_MASK, default 32'hF000_0000, address bits compared for slave 1.
REQ-005 Port clk, input, 1, the block's only clock; all state is updated on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port mst_axi_mosi_i, input, s_axi_mosi_t, request channels from the nox LSU master.
REQ-008 Port mst_axi_miso_o, output, s_axi_miso_t, response channels returned to the LSU master.
REQ-009 Port slv_axi_mosi_o, output, s_axi_mosi_t [1:0], request channels to slaves 0 and 1.
REQ-010 Port slv_axi_miso_i, input, s_axi_miso_t [1:0], response channels from slaves 0 and 1.

Function
REQ-011 Decode SHALL be hit_n = ((addr & Sn_MASK) == Sn_BASE); slave 0 SHALL win when both regions hit; no hit means unmapped.
REQ-012 The read FSM SHALL have the states RD_IDLE, RD_FWD and RD_ERR.
REQ-013 The write FSM SHALL have the states WR_IDLE, WR_DATA, WR_RESP, WR_ERR_DATA and WR_ERR_RESP.
REQ-014 The read and write FSMs SHALL be independent; each SHALL allow at most one outstanding transaction.
REQ-015 In RD_IDLE, arvalid SHALL pass combinationally only to the decoded slave, and master arready SHALL equal that slave's arready.
REQ-016 An AR handshake to a mapped slave SHALL register sel_rd and enter RD_FWD.
REQ-017 In RD_FWD, master arready SHALL be 0 and the R channel SHALL be routed from slave sel_rd, with rready routed back to it.
REQ-018 In RD_FWD, a handshake with rlast=1 SHALL return the FSM to RD_IDLE on the next cycle.
REQ-019 An unmapped arvalid in RD_IDLE SHALL see arready=1, capture arid and arlen, and enter RD_ERR without any slave seeing arvalid.
REQ-020 In RD_ERR the block SHALL drive rvalid=1, rresp=2'b11, rdata=0 and rid=captured arid, for arlen+1 beats counted by an 8-bit counter.
REQ-021 In RD_ERR, rlast SHALL be 1 only on the final beat, and that beat's handshake SHALL return the FSM to RD_IDLE.
REQ-022 In WR_IDLE, awvalid SHALL be routed to the decoded slave, and master wready SHALL be 0 (W may precede AW).
REQ-023 A mapped AW handshake SHALL register sel_wr and enter WR_DATA.
REQ-024 In WR_DATA the W channel SHALL be routed to slave sel_wr, and the wlast handshake SHALL enter WR_RESP.
REQ-025 In WR_RESP the B channel SHALL be routed from slave sel_wr, and the B handshake SHALL return the FSM to WR_IDLE.
REQ-026 An unmapped AW SHALL be accepted locally, capture awid and enter WR_ERR_DATA.
REQ-027 WR_ERR_DATA SHALL sink W beats with wready=1 until wlast, then enter WR_ERR_RESP.
REQ-028 WR_ERR_RESP SHALL drive bvalid=1, bresp=2'b11 and bid=captured awid until bready, then return to WR_IDLE.
REQ-029 A non-selected slave SHALL see valid=0 and ready=0 on every channel at all times.
REQ-030 Valid signals SHALL be held once asserted; selections SHALL NOT change while a transaction is open.
REQ-031 A simultaneous read and write to the same slave SHALL proceed concurrently on their separate channels.
REQ-032 Latency SHALL be zero added cycles on the AR/AW/W/R/B data paths; only the return to IDLE costs one cycle.

Reset
REQ-033 While rst=1, both FSMs SHALL be forced to IDLE and counters and captured IDs SHALL be cleared.
REQ-034 While rst=1, all valid and ready outputs on both sides SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction with no response issued; the slaves share the same rst.

Structure
REQ-036 The RD/WR state enums and the AXI_RESP_DECERR=2'b11 constant SHALL live in utils_pkg.
REQ-037 Address decode SHALL be a combinational function shared by AR and AW; no sub-module SHALL be instantiated.

Verification
REQ-038 Read of araddr=0x1000_0040 with arlen=3 -> only slave 0 sees arvalid; 4 R beats are routed with rlast on beat 4; FSM returns to idle.
REQ-039 Write of awaddr=0x2000_0008 with 1 beat of wdata=0xDEADBEEF -> slave 1 receives it; bresp=OKAY returns to master; slave 0 is untouched.
REQ-040 Read of araddr=0x5000_0000 with arlen=1, arid=2 -> 2 beats with rresp=2'b11, rdata=0, rid=2, rlast on beat 2; no slave activity.
REQ-041 Unmapped write with 2 W beats issued before AW -> wready=0 until AW is accepted; both beats are sunk; bresp=2'b11.
REQ-042 Concurrent read to slave 0 and write to slave 1, with rready held low 5 cycles -> both complete; rvalid and rdata are stable while stalled.
REQ-043 rst pulsed after the second of 4 read beats -> all outputs are 0 the next cycle; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/utils_pkg.sv
// Shared AXI types, response codes and FSM state encodings for the LSU demux.
package utils_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FWD,
    RD_ERR
  } rd_state_t;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP,
    WR_ERR_DATA,
    WR_ERR_RESP
  } wr_state_t;

  // Result of an address decode: hit says some slave claims the address,
  // sel says which one (slave 0 takes priority on overlap).
  typedef struct packed {
    logic hit;
    logic sel;
  } dec_t;

  // Master-to-slave channels (AW, W, AR payloads plus B/R ready).
  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  // Slave-to-master channels (AW/W/AR ready plus B and R payloads).
  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_lsu_demux.sv
// One-master, two-slave AXI demux for the LSU. Reads and writes run in
// independent FSMs with one outstanding transaction each; unmapped accesses
// are answered locally with DECERR.
module axi_lsu_demux
  import utils_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h1000_0000,
  parameter logic [31:0] S0_MASK = 32'hF000_0000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  s_axi_mosi_t       mst_axi_mosi_i,
  output s_axi_miso_t       mst_axi_miso_o,
  output s_axi_mosi_t [1:0] slv_axi_mosi_o,
  input  s_axi_miso_t [1:0] slv_axi_miso_i
);

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic                sel_rd;
  logic                sel_wr;
  logic [AXI_ID_W-1:0] rd_err_id;
  logic [AXI_ID_W-1:0] wr_err_id;
  logic [7:0]          rd_err_len;
  logic [7:0]          rd_beat;

  dec_t ar_dec;
  dec_t aw_dec;
  logic ar_fire, r_fire, aw_fire, w_fire, b_fire;
  logic rd_last_beat;

  function automatic dec_t decode(input logic [31:0] addr);
    dec_t d;
    d.hit = 1'b0;
    d.sel = 1'b0;
    if ((addr & S0_MASK) == S0_BASE) begin
      d.hit = 1'b1;
      d.sel = 1'b0;
    end else if ((addr & S1_MASK) == S1_BASE) begin
      d.hit = 1'b1;
      d.sel = 1'b1;
    end
    return d;
  endfunction

  // Payloads fan out to both slaves; only valids and readies are steered.
  function automatic s_axi_mosi_t quiet_req(input s_axi_mosi_t m);
    s_axi_mosi_t r;
    r         = m;
    r.awvalid = 1'b0;
    r.wvalid  = 1'b0;
    r.bready  = 1'b0;
    r.arvalid = 1'b0;
    r.rready  = 1'b0;
    return r;
  endfunction

  assign ar_dec       = decode(mst_axi_mosi_i.araddr);
  assign aw_dec       = decode(mst_axi_mosi_i.awaddr);
  assign ar_fire      = mst_axi_mosi_i.arvalid && mst_axi_miso_o.arready;
  assign r_fire       = mst_axi_miso_o.rvalid && mst_axi_mosi_i.rready;
  assign aw_fire      = mst_axi_mosi_i.awvalid && mst_axi_miso_o.awready;
  assign w_fire       = mst_axi_mosi_i.wvalid && mst_axi_miso_o.wready;
  assign b_fire       = mst_axi_miso_o.bvalid && mst_axi_mosi_i.bready;
  assign rd_last_beat = (rd_beat == rd_err_len);

  // Channel routing for both FSMs; everything stays quiet while in reset.
  always_comb begin
    mst_axi_miso_o    = '0;
    slv_axi_mosi_o[0] = quiet_req(mst_axi_mosi_i);
    slv_axi_mosi_o[1] = quiet_req(mst_axi_mosi_i);
    if (!rst) begin
      unique case (rd_state)
        RD_IDLE: begin
          if (ar_dec.hit) begin
            slv_axi_mosi_o[ar_dec.sel].arvalid = mst_axi_mosi_i.arvalid;
            mst_axi_miso_o.arready = slv_axi_miso_i[ar_dec.sel].arready;
          end else begin
            mst_axi_miso_o.arready = 1'b1;
          end
        end
        RD_FWD: begin
          mst_axi_miso_o.rvalid = slv_axi_miso_i[sel_rd].rvalid;
          mst_axi_miso_o.rdata  = slv_axi_miso_i[sel_rd].rdata;
          mst_axi_miso_o.rresp  = slv_axi_miso_i[sel_rd].rresp;
          mst_axi_miso_o.rid    = slv_axi_miso_i[sel_rd].rid;
          mst_axi_miso_o.rlast  = slv_axi_miso_i[sel_rd].rlast;
          slv_axi_mosi_o[sel_rd].rready = mst_axi_mosi_i.rready;
        end
        RD_ERR: begin
          mst_axi_miso_o.rvalid = 1'b1;
          mst_axi_miso_o.rdata  = '0;
          mst_axi_miso_o.rresp  = AXI_RESP_DECERR;
          mst_axi_miso_o.rid    = rd_err_id;
          mst_axi_miso_o.rlast  = rd_last_beat;
        end
        default: ;
      endcase

      unique case (wr_state)
        WR_IDLE: begin
          if (aw_dec.hit) begin
            slv_axi_mosi_o[aw_dec.sel].awvalid = mst_axi_mosi_i.awvalid;
            mst_axi_miso_o.awready = slv_axi_miso_i[aw_dec.sel].awready;
          end else begin
            mst_axi_miso_o.awready = 1'b1;
          end
        end
        WR_DATA: begin
          slv_axi_mosi_o[sel_wr].wvalid = mst_axi_mosi_i.wvalid;
          mst_axi_miso_o.wready = slv_axi_miso_i[sel_wr].wready;
        end
        WR_RESP: begin
          mst_axi_miso_o.bvalid = slv_axi_miso_i[sel_wr].bvalid;
          mst_axi_miso_o.bresp  = slv_axi_miso_i[sel_wr].bresp;
          mst_axi_miso_o.bid    = slv_axi_miso_i[sel_wr].bid;
          slv_axi_mosi_o[sel_wr].bready = mst_axi_mosi_i.bready;
        end
        WR_ERR_DATA: begin
          mst_axi_miso_o.wready = 1'b1;
        end
        WR_ERR_RESP: begin
          mst_axi_miso_o.bvalid = 1'b1;
          mst_axi_miso_o.bresp  = AXI_RESP_DECERR;
          mst_axi_miso_o.bid    = wr_err_id;
        end
        default: ;
      endcase
    end
  end

  // Read FSM next state.
  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (ar_fire) rd_next = ar_dec.hit ? RD_FWD : RD_ERR;
      RD_FWD:  if (r_fire && mst_axi_miso_o.rlast) rd_next = RD_IDLE;
      RD_ERR:  if (r_fire && rd_last_beat) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Write FSM next state.
  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      WR_IDLE:     if (aw_fire) wr_next = aw_dec.hit ? WR_DATA : WR_ERR_DATA;
      WR_DATA:     if (w_fire && mst_axi_mosi_i.wlast) wr_next = WR_RESP;
      WR_RESP:     if (b_fire) wr_next = WR_IDLE;
      WR_ERR_DATA: if (w_fire && mst_axi_mosi_i.wlast) wr_next = WR_ERR_RESP;
      WR_ERR_RESP: if (b_fire) wr_next = WR_IDLE;
      default:     wr_next = WR_IDLE;
    endcase
  end

  // Read state, slave selection and DECERR beat bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      sel_rd     <= 1'b0;
      rd_err_id  <= '0;
      rd_err_len <= '0;
      rd_beat    <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_state == RD_IDLE && ar_fire) begin
        rd_beat <= '0;
        if (ar_dec.hit) begin
          sel_rd <= ar_dec.sel;
        end else begin
          rd_err_id  <= mst_axi_mosi_i.arid;
          rd_err_len <= mst_axi_mosi_i.arlen;
        end
      end else if (rd_state == RD_ERR && r_fire) begin
        rd_beat <= rd_beat + 8'd1;
      end
    end
  end

  // Write state, slave selection and captured AWID for DECERR responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= WR_IDLE;
      sel_wr    <= 1'b0;
      wr_err_id <= '0;
    end else begin
      wr_state <= wr_next;
      if (wr_state == WR_IDLE && aw_fire) begin
        if (aw_dec.hit) sel_wr <= aw_dec.sel;
        else            wr_err_id <= mst_axi_mosi_i.awid;
      end
    end
  end

endmodule

// File: tb/tb_axi_lsu_demux.sv
// Scoreboard bench for axi_lsu_demux: two simple AXI slave models, a master
// driver, and a negedge monitor that checks every R/B handshake on the master.
module tb_axi_lsu_demux;
  import utils_pkg::*;

  logic clk = 1'b0;
  logic rst;
  s_axi_mosi_t       mst_mosi;
  s_axi_miso_t       mst_miso;
  s_axi_mosi_t [1:0] slv_mosi;
  s_axi_miso_t [1:0] slv_miso;

  always #5 clk = ~clk;

  axi_lsu_demux dut (
    .clk            (clk),
    .rst            (rst),
    .mst_axi_mosi_i (mst_mosi),
    .mst_axi_miso_o (mst_miso),
    .slv_axi_mosi_o (slv_mosi),
    .slv_axi_miso_i (slv_miso)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
  } r_exp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  r_exp_t r_q[$];
  b_exp_t b_q[$];
  int checks = 0;
  int errors = 0;

  // Slave model state.
  logic        s_rd_busy [2];
  logic [7:0]  s_rd_beat [2];
  logic [7:0]  s_rd_len  [2];
  logic [3:0]  s_rd_id   [2];
  logic [1:0]  s_wr_st   [2];
  logic [3:0]  s_bid     [2];
  logic [31:0] s_wdata   [2];
  int arv_seen [2];
  int awv_seen [2];
  int wv_seen  [2];

  function automatic logic [31:0] slave_data(int s, logic [7:0] k);
    return 32'hA000_0000 | (32'(s) << 16) | {24'h0, k};
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave response drive: always ready for a new AR/AW when idle.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      slv_miso[s]         = '0;
      slv_miso[s].arready = !s_rd_busy[s];
      slv_miso[s].rvalid  = s_rd_busy[s];
      slv_miso[s].rdata   = slave_data(s, s_rd_beat[s]);
      slv_miso[s].rid     = s_rd_id[s];
      slv_miso[s].rresp   = AXI_RESP_OKAY;
      slv_miso[s].rlast   = (s_rd_beat[s] == s_rd_len[s]);
      slv_miso[s].awready = (s_wr_st[s] == 2'd0);
      slv_miso[s].wready  = (s_wr_st[s] == 2'd1);
      slv_miso[s].bvalid  = (s_wr_st[s] == 2'd2);
      slv_miso[s].bid     = s_bid[s];
      slv_miso[s].bresp   = AXI_RESP_OKAY;
    end
  end

  // Slave model state updates on handshakes.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        s_rd_busy[s] <= 1'b0;
        s_rd_beat[s] <= '0;
        s_rd_len[s]  <= '0;
        s_rd_id[s]   <= '0;
        s_wr_st[s]   <= 2'd0;
        s_bid[s]     <= '0;
      end else begin
        if (slv_mosi[s].arvalid && slv_miso[s].arready) begin
          s_rd_busy[s] <= 1'b1;
          s_rd_beat[s] <= '0;
          s_rd_len[s]  <= slv_mosi[s].arlen;
          s_rd_id[s]   <= slv_mosi[s].arid;
        end else if (slv_miso[s].rvalid && slv_mosi[s].rready) begin
          if (slv_miso[s].rlast) s_rd_busy[s] <= 1'b0;
          else                   s_rd_beat[s] <= s_rd_beat[s] + 8'd1;
        end
        case (s_wr_st[s])
          2'd0: if (slv_mosi[s].awvalid) begin
            s_wr_st[s] <= 2'd1;
            s_bid[s]   <= slv_mosi[s].awid;
          end
          2'd1: if (slv_mosi[s].wvalid) begin
            s_wdata[s] <= slv_mosi[s].wdata;
            if (slv_mosi[s].wlast) s_wr_st[s] <= 2'd2;
          end
          2'd2: if (slv_mosi[s].bready) s_wr_st[s] <= 2'd0;
          default: s_wr_st[s] <= 2'd0;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every master R/B handshake and checks
  // that a stalled R beat holds its value.
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  r_exp_t      r_e;
  b_exp_t      b_e;
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (slv_mosi[s].arvalid) arv_seen[s]++;
      if (slv_mosi[s].awvalid) awv_seen[s]++;
      if (slv_mosi[s].wvalid)  wv_seen[s]++;
    end
    if (!rst) begin
      if (stall_prev)
        check_output("r_stall_hold", {31'h0, mst_miso.rvalid, mst_miso.rdata}, {31'h0, 1'b1, stall_data});
      stall_prev = mst_miso.rvalid && !mst_mosi.rready;
      stall_data = mst_miso.rdata;
      if (mst_miso.rvalid && mst_mosi.rready) begin
        if (r_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL r_unexpected: got beat data %h resp %b, required none", mst_miso.rdata, mst_miso.rresp);
        end else begin
          r_e = r_q.pop_front();
          check_output("r_beat", 64'({mst_miso.rdata, mst_miso.rresp, mst_miso.rid, mst_miso.rlast}), 64'(r_e));
        end
      end
      if (mst_miso.bvalid && mst_mosi.bready) begin
        if (b_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL b_unexpected: got bresp %b bid %h, required none", mst_miso.bresp, mst_miso.bid);
        end else begin
          b_e = b_q.pop_front();
          check_output("b_resp", 64'({mst_miso.bresp, mst_miso.bid}), 64'(b_e));
        end
      end
    end
  end

  function automatic logic ready_of(int which);
    case (which)
      0:       return mst_miso.arready;
      1:       return mst_miso.awready;
      default: return mst_miso.wready;
    endcase
  endfunction

  // Waits (bounded) until the selected master-side ready completes a handshake.
  task automatic wait_ready(int which, string name);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ready_of(which)) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s_timeout: got no ready in 50 cycles, required handshake", name);
  endtask

  task automatic do_ar(logic [31:0] addr, logic [7:0] len, logic [3:0] id);
    mst_mosi.araddr  = addr;
    mst_mosi.arlen   = len;
    mst_mosi.arid    = id;
    mst_mosi.arsize  = 3'd2;
    mst_mosi.arburst = 2'b01;
    mst_mosi.arvalid = 1'b1;
    wait_ready(0, "ar");
    mst_mosi.arvalid = 1'b0;
  endtask

  // Issues a read and queues the beats it should produce (slave -1 = unmapped).
  task automatic issue_read(logic [31:0] addr, logic [7:0] len, logic [3:0] id, int slave);
    for (int k = 0; k <= int'(len); k++)
      r_q.push_back({(slave < 0) ? 32'h0 : slave_data(slave, 8'(k)),
                     (slave < 0) ? AXI_RESP_DECERR : AXI_RESP_OKAY, id, k == int'(len)});
    do_ar(addr, len, id);
  endtask

  task automatic issue_write(logic [31:0] addr, logic [3:0] id, logic [31:0] d0, int nbeats, logic [1:0] resp);
    b_q.push_back({resp, id});
    mst_mosi.awaddr  = addr;
    mst_mosi.awid    = id;
    mst_mosi.awlen   = 8'(nbeats - 1);
    mst_mosi.awsize  = 3'd2;
    mst_mosi.awburst = 2'b01;
    mst_mosi.awvalid = 1'b1;
    wait_ready(1, "aw");
    mst_mosi.awvalid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      mst_mosi.wdata  = d0 + 32'(k);
      mst_mosi.wstrb  = 4'hF;
      mst_mosi.wlast  = (k == nbeats - 1);
      mst_mosi.wvalid = 1'b1;
      wait_ready(2, "w");
      mst_mosi.wvalid = 1'b0;
    end
  endtask

  task automatic drain(string name);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (r_q.size() == 0 && b_q.size() == 0) begin
        repeat (2) @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s_drain: got %0d R and %0d B pending, required 0", name, r_q.size(), b_q.size());
    r_q.delete();
    b_q.delete();
  endtask

  task automatic check_quiet(string name);
    check_output({name, "_mst"}, 64'({mst_miso.arready, mst_miso.awready, mst_miso.wready,
                                      mst_miso.rvalid, mst_miso.bvalid}), 64'h0);
    for (int s = 0; s < 2; s++)
      check_output({name, "_slv"}, 64'({slv_mosi[s].arvalid, slv_mosi[s].awvalid, slv_mosi[s].wvalid,
                                        slv_mosi[s].rready, slv_mosi[s].bready}), 64'h0);
  endtask

  int a0, a1, w0, w1, v0, v1;

  task automatic snap();
    a0 = arv_seen[0]; a1 = arv_seen[1];
    w0 = awv_seen[0]; w1 = awv_seen[1];
    v0 = wv_seen[0];  v1 = wv_seen[1];
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      arv_seen[s] = 0; awv_seen[s] = 0; wv_seen[s] = 0; s_wdata[s] = '0;
    end
    mst_mosi = '0;
    // Reset with every request valid and every response ready asserted.
    rst = 1'b1;
    mst_mosi.araddr  = 32'h1000_0000;
    mst_mosi.awaddr  = 32'h2000_0000;
    mst_mosi.arvalid = 1'b1;
    mst_mosi.awvalid = 1'b1;
    mst_mosi.wvalid  = 1'b1;
    mst_mosi.rready  = 1'b1;
    mst_mosi.bready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    mst_mosi.arvalid = 1'b0;
    mst_mosi.awvalid = 1'b0;
    mst_mosi.wvalid  = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Mapped 4-beat read to slave 0.
    snap();
    issue_read(32'h1000_0040, 8'd3, 4'd1, 0);
    drain("rd_s0");
    check_output("rd_s0_arvalid_s0", 64'(arv_seen[0] - a0), 64'd1);
    check_output("rd_s0_arvalid_s1", 64'(arv_seen[1] - a1), 64'd0);

    // Single-beat write to slave 1.
    snap();
    issue_write(32'h2000_0008, 4'd5, 32'hDEAD_BEEF, 1, AXI_RESP_OKAY);
    drain("wr_s1");
    check_output("wr_s1_data", 64'(s_wdata[1]), 64'hDEAD_BEEF);
    check_output("wr_s1_seen_s1", 64'({awv_seen[1] - w1, wv_seen[1] - v1}), {32'd1, 32'd1});
    check_output("wr_s1_seen_s0", 64'({awv_seen[0] - w0, wv_seen[0] - v0}), 64'd0);

    // Unmapped read: two DECERR beats, no slave activity.
    snap();
    issue_read(32'h5000_0000, 8'd1, 4'd2, -1);
    drain("rd_err");
    check_output("rd_err_no_slave", 64'({arv_seen[0] - a0, arv_seen[1] - a1}), 64'd0);

    // Unmapped write with W presented before AW.
    snap();
    mst_mosi.wdata  = 32'h0000_1111;
    mst_mosi.wstrb  = 4'hF;
    mst_mosi.wlast  = 1'b0;
    mst_mosi.wvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("wr_err_w_early", 64'(mst_miso.wready), 64'd0);
    end
    @(posedge clk);
    #1;
    issue_write(32'h7000_0000, 4'd3, 32'h0000_1111, 2, AXI_RESP_DECERR);
    drain("wr_err");
    check_output("wr_err_no_slave", 64'({awv_seen[0] - w0, awv_seen[1] - w1,
                                         wv_seen[0] - v0, wv_seen[1] - v1}), 64'd0);

    // Concurrent read to slave 0 (stalled R) and write to slave 1.
    mst_mosi.rready = 1'b0;
    fork
      issue_read(32'h1000_0100, 8'd2, 4'd4, 0);
      issue_write(32'h2000_0010, 4'd6, 32'h5555_0000, 2, AXI_RESP_OKAY);
    join
    repeat (5) @(posedge clk);
    #1;
    mst_mosi.rready = 1'b1;
    drain("concurrent");
    check_output("concurrent_wdata", 64'(s_wdata[1]), 64'h5555_0001);

    // Reset in the middle of a 4-beat read, after the second beat.
    r_q.push_back({slave_data(0, 8'd0), AXI_RESP_OKAY, 4'd7, 1'b0});
    r_q.push_back({slave_data(0, 8'd1), AXI_RESP_OKAY, 4'd7, 1'b0});
    do_ar(32'h1000_0200, 8'd3, 4'd7);
    for (int c = 0; c < 50 && r_q.size() != 0; c++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_quiet("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst_abandon", 64'({mst_miso.rvalid, mst_miso.bvalid}), 64'd0);
    @(posedge clk);
    #1;
    issue_read(32'h2000_0100, 8'd1, 4'd9, 1);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
